// File: rtl/arm_ctrl_pkg.sv
// Shared definitions for the ARMv4 multicycle controller: state encodings,
// instruction-class opcodes and datapath mux-select values.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] SRCA_REG = 2'd0;
    localparam logic [1:0] SRCA_PC  = 2'd1;

    localparam logic [1:0] SRCB_REG  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [1:0] RES_ALUOUT    = 2'd0;
    localparam logic [1:0] RES_DATA      = 2'd1;
    localparam logic [1:0] RES_ALURESULT = 2'd2;

    // An instruction retires on the edge that leaves its final state.
    function automatic logic is_retire(input state_t s, input logic mem_ready);
        logic r;
        case (s)
            S_MEMWB, S_ALUWB, S_BRANCH: r = 1'b1;
            S_MEMWR:                    r = mem_ready;
            default:                    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle main controller: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and write enables, and counts retired instructions.
module arm_multicycle_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       op,
    input  logic             funct5,
    input  logic             funct0,
    input  logic             condEx,
    input  logic             memReady,
    output logic             irW,
    output logic             nextPC,
    output logic             branch,
    output logic             adrSrc,
    output logic [1:0]       aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [1:0]       resultSrc,
    output logic             aluOp,
    output logic             memW,
    output logic             regW,
    output logic [1:0]       immSrc,
    output logic [1:0]       regSrc,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instrCount
);

    state_t           state_r;
    state_t           state_n_s;
    logic [CNT_W-1:0] instr_count_r;
    logic             irw_s;
    logic             branch_s;
    logic             memw_s;
    logic             regw_s;
    logic             illegal_s;
    logic             retire_s;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next-state and Moore output decode; unknown encodings act as FETCH.
    always_comb begin
        state_n_s = S_FETCH;
        irw_s     = 1'b0;
        branch_s  = 1'b0;
        memw_s    = 1'b0;
        regw_s    = 1'b0;
        illegal_s = 1'b0;
        adrSrc    = 1'b0;
        aluSrcA   = SRCA_REG;
        aluSrcB   = SRCB_REG;
        resultSrc = RES_ALUOUT;
        aluOp     = 1'b0;
        case (state_r)
            S_DECODE: begin
                aluSrcA   = SRCA_PC;
                aluSrcB   = SRCB_FOUR;
                resultSrc = RES_ALURESULT;
                case (op)
                    OP_MEM: state_n_s = S_MEMADR;
                    OP_DP: begin
                        if (funct5) begin
                            state_n_s = S_EXECI;
                        end else begin
                            state_n_s = S_EXECR;
                        end
                    end
                    OP_BR: state_n_s = S_BRANCH;
                    default: begin
                        illegal_s = 1'b1;
                        state_n_s = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                aluSrcB = SRCB_IMM;
                if (funct0) begin
                    state_n_s = S_MEMRD;
                end else begin
                    state_n_s = S_MEMWR;
                end
            end
            S_MEMRD: begin
                adrSrc = 1'b1;
                if (memReady) begin
                    state_n_s = S_MEMWB;
                end else begin
                    state_n_s = S_MEMRD;
                end
            end
            S_MEMWB: begin
                resultSrc = RES_DATA;
                regw_s    = condEx;
                state_n_s = S_FETCH;
            end
            S_MEMWR: begin
                adrSrc = 1'b1;
                memw_s = condEx;
                if (memReady) begin
                    state_n_s = S_FETCH;
                end else begin
                    state_n_s = S_MEMWR;
                end
            end
            S_EXECR: begin
                aluOp     = 1'b1;
                state_n_s = S_ALUWB;
            end
            S_EXECI: begin
                aluSrcB   = SRCB_IMM;
                aluOp     = 1'b1;
                state_n_s = S_ALUWB;
            end
            S_ALUWB: begin
                regw_s    = condEx;
                state_n_s = S_FETCH;
            end
            S_BRANCH: begin
                aluSrcB   = SRCB_IMM;
                resultSrc = RES_ALURESULT;
                branch_s  = condEx;
                state_n_s = S_FETCH;
            end
            default: begin
                aluSrcA   = SRCA_PC;
                aluSrcB   = SRCB_FOUR;
                resultSrc = RES_ALURESULT;
                irw_s     = memReady;
                if (memReady) begin
                    state_n_s = S_DECODE;
                end else begin
                    state_n_s = S_FETCH;
                end
            end
        endcase
    end

    assign retire_s = is_retire(state_r, memReady);

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_count_r <= '0;
        end else if (retire_s) begin
            instr_count_r <= instr_count_r + CNT_W'(1);
        end else begin
            instr_count_r <= instr_count_r;
        end
    end

    // Write-type strobes are masked during reset so nothing leaks mid-abort.
    assign irW        = irw_s & ~reset;
    assign nextPC     = irw_s & ~reset;
    assign branch     = branch_s & ~reset;
    assign memW       = memw_s & ~reset;
    assign regW       = regw_s & ~reset;
    assign illegal    = illegal_s & ~reset;
    assign immSrc     = op;
    assign regSrc     = {(op == OP_MEM), (op == OP_BR)};
    assign state      = state_r;
    assign instrCount = instr_count_r;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Self-checking bench for arm_multicycle_ctrl: per-cycle expected outputs are
// queued per instruction and compared as the FSM walks through its states.
module tb_arm_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  op;
    logic        funct5, funct0, condEx, memReady;

    logic        irW, nextPC, branch, adrSrc, aluOp, memW, regW, illegal;
    logic [1:0]  aluSrcA, aluSrcB, resultSrc, immSrc, regSrc;
    logic [3:0]  state;
    logic [31:0] instrCount;

    logic        irW4, nextPC4, branch4, adrSrc4, aluOp4, memW4, regW4, illegal4;
    logic [1:0]  aluSrcA4, aluSrcB4, resultSrc4, immSrc4, regSrc4;
    logic [3:0]  state4;
    logic [3:0]  instrCount4;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 32'd0;

    typedef struct packed {
        logic        rdy;
        logic [17:0] vec;
    } ent_t;
    ent_t q[$];

    logic [17:0] obs;
    assign obs = {state, irW, nextPC, branch, adrSrc, aluSrcA, aluSrcB, resultSrc,
                  aluOp, memW, regW, illegal};

    always #5 clk = ~clk;

    arm_multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .funct5(funct5), .funct0(funct0),
        .condEx(condEx), .memReady(memReady), .irW(irW), .nextPC(nextPC),
        .branch(branch), .adrSrc(adrSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
        .resultSrc(resultSrc), .aluOp(aluOp), .memW(memW), .regW(regW),
        .immSrc(immSrc), .regSrc(regSrc), .illegal(illegal), .state(state),
        .instrCount(instrCount)
    );

    arm_multicycle_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .op(op), .funct5(funct5), .funct0(funct0),
        .condEx(condEx), .memReady(memReady), .irW(irW4), .nextPC(nextPC4),
        .branch(branch4), .adrSrc(adrSrc4), .aluSrcA(aluSrcA4), .aluSrcB(aluSrcB4),
        .resultSrc(resultSrc4), .aluOp(aluOp4), .memW(memW4), .regW(regW4),
        .immSrc(immSrc4), .regSrc(regSrc4), .illegal(illegal4), .state(state4),
        .instrCount(instrCount4)
    );

    // Expected outputs for a state, straight from the controller's output table.
    function automatic logic [17:0] exp_vec(input logic [3:0] st, input logic rdy,
                                            input logic cex, input logic [1:0] opc);
        logic irw, br, adr, aop, mw, rw, ill;
        logic [1:0] a, b, r;
        irw = 1'b0; br = 1'b0; adr = 1'b0; aop = 1'b0; mw = 1'b0; rw = 1'b0; ill = 1'b0;
        a = 2'd0; b = 2'd0; r = 2'd0;
        case (st)
            4'd0: begin a = 2'd1; b = 2'd2; r = 2'd2; irw = rdy; end
            4'd1: begin a = 2'd1; b = 2'd2; r = 2'd2; ill = (opc == 2'b11); end
            4'd2: begin b = 2'd1; end
            4'd3: begin adr = 1'b1; end
            4'd4: begin r = 2'd1; rw = cex; end
            4'd5: begin adr = 1'b1; mw = cex; end
            4'd6: begin aop = 1'b1; end
            4'd7: begin b = 2'd1; aop = 1'b1; end
            4'd8: begin rw = cex; end
            4'd9: begin b = 2'd1; r = 2'd2; br = cex; end
            default: ;
        endcase
        return {st, irw, irw, br, adr, a, b, r, aop, mw, rw, ill};
    endfunction

    task automatic push(input logic [3:0] st, input logic rdy);
        ent_t e;
        e.rdy = rdy;
        e.vec = exp_vec(st, rdy, condEx, op);
        q.push_back(e);
    endtask

    // Queue the expected cycle trace for one instruction, then replay it.
    task automatic run_instr(input string name, input logic [1:0] op_i, input logic f5,
                             input logic f0, input logic cex, input int fw, input int mw);
        ent_t e;
        int   cyc;
        op = op_i; funct5 = f5; funct0 = f0; condEx = cex;
        for (int i = 0; i < fw; i++) push(4'd0, 1'b0);
        push(4'd0, 1'b1);
        push(4'd1, 1'b1);
        case (op_i)
            2'b01: begin
                push(4'd2, 1'b1);
                if (f0) begin
                    for (int i = 0; i < mw; i++) push(4'd3, 1'b0);
                    push(4'd3, 1'b1);
                    push(4'd4, 1'b1);
                end else begin
                    for (int i = 0; i < mw; i++) push(4'd5, 1'b0);
                    push(4'd5, 1'b1);
                end
            end
            2'b00: begin
                push(f5 ? 4'd7 : 4'd6, 1'b1);
                push(4'd8, 1'b1);
            end
            2'b10: push(4'd9, 1'b1);
            default: ;
        endcase
        if (op_i != 2'b11) exp_cnt = exp_cnt + 32'd1;
        cyc = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            memReady = e.rdy;
            #1;
            checks++;
            if (obs !== e.vec) begin
                errors++;
                $display("FAIL %s cycle %0d: outputs got %h expected %h", name, cyc, obs, e.vec);
            end
            cyc++;
        end
        @(negedge clk);
        memReady = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || instrCount !== exp_cnt || instrCount4 !== exp_cnt[3:0]) begin
            errors++;
            $display("FAIL %s end: state %0d cnt %0d cnt4 %0d expected state 0 cnt %0d cnt4 %0d",
                     name, state, instrCount, instrCount4, exp_cnt, exp_cnt[3:0]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; op = 2'b00; funct5 = 1'b0; funct0 = 1'b0; condEx = 1'b1; memReady = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (state !== 4'd0 || irW !== 1'b0 || nextPC !== 1'b0 || instrCount !== 32'd0 ||
            instrCount4 !== 4'd0) begin
            errors++;
            $display("FAIL reset: state %0d irW %b nextPC %b cnt %0d expected 0 0 0 0",
                     state, irW, nextPC, instrCount);
        end
        memReady = 1'b0;
        reset = 1'b0;
        exp_cnt = 32'd0;
    endtask

    task automatic test_imm_regsrc();
        logic [1:0] o;
        for (int i = 0; i < 4; i++) begin
            o = i[1:0];
            op = o;
            #1;
            checks++;
            if (immSrc !== o || regSrc !== {o == 2'b01, o == 2'b10}) begin
                errors++;
                $display("FAIL imm_regsrc op %0d: immSrc %0d regSrc %b expected %0d %b",
                         o, immSrc, regSrc, o, {o == 2'b01, o == 2'b10});
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            run_instr("back_to_back", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_async_reset();
        op = 2'b01; funct5 = 1'b0; funct0 = 1'b0; condEx = 1'b1;
        @(negedge clk); memReady = 1'b1;
        @(negedge clk); memReady = 1'b1;
        @(negedge clk); memReady = 1'b1;
        @(negedge clk); memReady = 1'b0;
        #1;
        checks++;
        if (state !== 4'd5 || memW !== 1'b1) begin
            errors++;
            $display("FAIL async_reset pre: state %0d memW %b expected 5 1", state, memW);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0 || memW !== 1'b0 || instrCount !== 32'd0 || instrCount4 !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: state %0d memW %b cnt %0d cnt4 %0d expected 0 0 0 0",
                     state, memW, instrCount, instrCount4);
        end
        exp_cnt = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        memReady = 1'b0;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) run_instr("wrap", 2'b00, 1'b1, 1'b0, 1'b1, 0, 0);
        checks++;
        if (instrCount4 !== 4'd0 || instrCount !== 32'd16) begin
            errors++;
            $display("FAIL wrap: cnt4 %0d cnt %0d expected 0 16", instrCount4, instrCount);
        end
    endtask

    initial begin
        test_reset();
        run_instr("fetch_stall_dp_imm", 2'b00, 1'b1, 1'b0, 1'b1, 3, 0);
        run_instr("dp_reg_cex0", 2'b00, 1'b0, 1'b1, 1'b0, 0, 0);
        run_instr("load_wait", 2'b01, 1'b0, 1'b1, 1'b1, 0, 2);
        run_instr("store_cex0", 2'b01, 1'b1, 1'b0, 1'b0, 0, 2);
        run_instr("store_cex1", 2'b01, 1'b0, 1'b0, 1'b1, 1, 1);
        run_instr("branch", 2'b10, 1'b0, 1'b0, 1'b1, 0, 0);
        run_instr("branch_cex0", 2'b10, 1'b1, 1'b1, 1'b0, 0, 0);
        run_instr("illegal", 2'b11, 1'b0, 1'b0, 1'b1, 0, 0);
        test_imm_regsrc();
        test_back_to_back();
        test_async_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arm_multicycle_ctrl.md
Name: arm_multicycle_ctrl

Overview:
Multicycle main controller FSM for the ARMv4 core. It is the sequential counterpart of the single-cycle main decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback cycles.
- Drives the multicycle datapath muxes and write enables.
- Handshakes with a variable-latency memory via memReady.
- Counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
op  in  2  instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 illegal
funct5  in  1  instr[25] (I bit: immediate operand)
funct0  in  1  instr[20] (L bit for memory; S bit otherwise)
condEx  in  1  condition-check result from the conditional-logic unit, valid from DECODE onward
memReady  in  1  memory has completed the current access this cycle
irW  out  1  instruction register write enable
nextPC  out  1  PC update request (fetch increment)
branch  out  1  branch-taken PC write request
adrSrc  out  1  memory address: 0 PC, 1 ALUResult register
aluSrcA  out  2  0 register A, 1 PC
aluSrcB  out  2  0 register B (WriteData), 1 ExtImm, 2 constant 4
resultSrc  out  2  0 ALUOut, 1 Data register, 2 ALUResult (direct)
aluOp  out  1  1 = ALU decoder uses funct; 0 = add
memW  out  1  memory write enable
regW  out  1  register file write enable
immSrc  out  2  extender select, equals op
regSrc  out  2  regSrc[0]=(op==10), regSrc[1]=(op==01)
illegal  out  1  op==11 seen in DECODE
state  out  4  current state encoding, for debug
instrCount  out  CNT_W  retired-instruction count

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Any other encoding behaves as FETCH and goes to FETCH next.
- Reset (async, active-high): state=FETCH and instrCount=0 immediately. While reset is high, irW, nextPC, branch, memW, regW and illegal are forced to 0.
- Outputs are Moore (decoded from state). Exceptions: irW/nextPC depend on memReady; regW/memW/branch depend on condEx. immSrc and regSrc are purely combinational from op.
- All outputs not listed for a state are 0.
- FETCH: adrSrc=0, aluSrcA=1, aluSrcB=2, resultSrc=2, irW=nextPC=memReady. Next state: DECODE if memReady, else stay.
- DECODE: aluSrcA=1, aluSrcB=2, resultSrc=2. Next state by op:
  - op=01 -> MEMADR
  - op=00 & !funct5 -> EXECR
  - op=00 & funct5 -> EXECI
  - op=10 -> BRANCH
  - op=11 -> FETCH, with illegal=1 for this cycle
- MEMADR: aluSrcA=0, aluSrcB=1, aluOp=0. Next state: MEMRD if funct0, else MEMWR.
- MEMRD: adrSrc=1. Next state: MEMWB if memReady, else stay.
- MEMWB: resultSrc=1, regW=condEx. Next state: FETCH.
- MEMWR: adrSrc=1, memW=condEx, held every cycle while waiting. Next state: FETCH if memReady, else stay.
- EXECR: aluSrcA=0, aluSrcB=0, aluOp=1. Next state: ALUWB.
- EXECI: aluSrcA=0, aluSrcB=1, aluOp=1. Next state: ALUWB.
- ALUWB: resultSrc=0, regW=condEx. Next state: FETCH.
- BRANCH: aluSrcA=0, aluSrcB=1, resultSrc=2, branch=condEx. Next state: FETCH.
- Latency with memReady tied high:
  - data-processing: 4 cycles
  - branch: 3 cycles
  - load: 5 cycles
  - store: 4 cycles
  - Each cycle with memReady low in FETCH, MEMRD or MEMWR adds one cycle.
- instrCount: +1 on the clock edge that leaves MEMWB, ALUWB or BRANCH, or leaves MEMWR with memReady. It counts regardless of condEx. Illegal instructions do not count. Wraps modulo 2^CNT_W.
- Reset mid-instruction: the FSM abandons the instruction with no partial writes and returns to FETCH.

Decomposition:
- Shared package arm_ctrl_pkg holds:
  - state enum (4-bit) with the encodings above
  - op constants OP_DP=00, OP_MEM=01, OP_BR=10
  - mux-select constants for aluSrcA/B and resultSrc
- Single module with a state register, next-state logic and output decode. The counter is inline; no sub-module.

Test Plan:
- Reset and memReady stall: reset high, then low with memReady=0 for 3 cycles -> state stays 0, irW=0; memReady=1 -> irW=1, nextPC=1 that cycle, state=1 next cycle.
- Data-processing: op=00, funct5=1, condEx=1, memReady=1 -> states 0,1,7,8,0; regW=1 only in ALUWB; aluOp=1 in EXECI; instrCount 0->1.
- Load with memory wait: op=01, funct0=1, memReady low 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; adrSrc=1 in MEMRD; resultSrc=1 and regW=1 in MEMWB.
- Store with condEx=0: op=01, funct0=0 -> MEMWR with memW=0 throughout; instrCount still increments.
- Branch and illegal: op=10, condEx=1 -> branch=1 in BRANCH, 3 cycles total. op=11 -> illegal=1 in DECODE, return to FETCH, instrCount unchanged.
- Async reset mid-MEMWR: assert reset between edges -> state=0 immediately, memW=0, instrCount=0; counter wrap check with CNT_W=4: 16 instructions -> 0.
